vid_mem_resp: RTL and testbench

VID_MEM_RESP -- requirements
Module: vid_mem_resp

---
 rtl/vid_bus_pkg.sv | 37 +++
 rtl/vid_mem_ram.sv | 39 +++
 rtl/vid_mem_resp.sv | 264 ++++++++++++++++++++++++++
 tb/tb_vid_mem_resp.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vid_bus_pkg.sv
// ---------------------------------------------------------------------------
// vid_bus_pkg
//   Shared definitions for the video-bus memory responder:
//     - bus command encodings (requests from the initiator, responses back)
//     - arbiter bid encodings
//     - responder FSM state type
//     - burst length code to beat count conversion
// ---------------------------------------------------------------------------
package vid_bus_pkg;

   // Bus commands
   localparam logic [2:0] CMD_IDLE   = 3'b000;
   localparam logic [2:0] CMD_WDATA  = 3'b001;
   localparam logic [2:0] CMD_RDREQ  = 3'b010;
   localparam logic [2:0] CMD_RDATA  = 3'b011;
   localparam logic [2:0] CMD_WRREQ  = 3'b100;
   localparam logic [2:0] CMD_WRRESP = 3'b101;

   // Arbiter bid values
   localparam logic [1:0] REQ_NONE = 2'b00;
   localparam logic [1:0] REQ_BID  = 2'b11;

   // Responder FSM states
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_DATA = 3'd1,
      WR_BID  = 3'd2,
      RD_BID  = 3'd3,
      RD_DATA = 3'd4
   } state_t;

   // Burst length code: 00=1, 01=2, 10=4, 11=8 beats
   function automatic logic [3:0] len_to_beats(input logic [1:0] len);
      len_to_beats = 4'd1 << len;
   endfunction

endpackage : vid_bus_pkg

// File: rtl/vid_mem_ram.sv
// ---------------------------------------------------------------------------
// vid_mem_ram
//   WORDS x 32 local memory with one synchronous write port and one
//   synchronous read port. Read data is registered (one-cycle latency) and
//   the array is never reset so it maps onto block RAM.
//
// Ports
//   clk      : clock, all activity on posedge
//   wr_en    : write strobe
//   wr_addr  : write word index
//   wr_data  : write data
//   rd_addr  : read word index, sampled every cycle
//   rd_data  : registered read data (mem[rd_addr] from the previous edge)
// ---------------------------------------------------------------------------
module vid_mem_ram #(
   parameter int  WORDS = 256,
   localparam int AW    = $clog2(WORDS)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [31:0]   wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [31:0]   rd_data
);

   logic [31:0] mem_reg [0:WORDS-1];
   logic [31:0] rd_data_reg;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_reg[wr_addr] <= wr_data;
      end
      rd_data_reg <= mem_reg[rd_addr];
   end

   assign rd_data = rd_data_reg;

endmodule : vid_mem_ram

// File: rtl/vid_mem_resp.sv
// ---------------------------------------------------------------------------
// vid_mem_resp
//   Video-bus memory target. Accepts write bursts into a local memory and
//   answers them with a single write-response cycle, and accepts read
//   requests which it answers with a gap-free burst of read data beats once
//   the arbiter grants its bid.
//
// Parameters
//   MEM_WORDS : number of 32-bit words in the local memory (power of 2)
//   VID_ID    : initiator ID presented on reqtar while responding
//
// Ports
//   clk         : clock, all logic on posedge
//   reset_n     : asynchronous active-low reset
//   selin       : this target is addressed in the current bus cycle
//   cmdin       : bus command (idle / write data / read req / write req)
//   lenin       : burst length code (00=1, 01=2, 10=4, 11=8 beats)
//   addrdatain  : byte address in request phase, write data in data phase
//   ackin       : arbiter grant for the pending bid
//   reqout      : arbiter bid, 11 while bidding else 00
//   cmdout      : response command (011 read data, 101 write resp, 000)
//   lenout      : captured length echoed during a response
//   addrdataout : read data beat, else 0
//   reqtar      : VID_ID while cmdout is non-zero, else 0
// ---------------------------------------------------------------------------
module vid_mem_resp
   import vid_bus_pkg::*;
#(
   parameter int         MEM_WORDS = 256,
   parameter logic [3:0] VID_ID    = 4'h1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        selin,
   input  logic [2:0]  cmdin,
   input  logic [1:0]  lenin,
   input  logic [31:0] addrdatain,
   input  logic        ackin,
   output logic [1:0]  reqout,
   output logic [2:0]  cmdout,
   output logic [1:0]  lenout,
   output logic [31:0] addrdataout,
   output logic [3:0]  reqtar
);

   localparam int AW = $clog2(MEM_WORDS);

   // FSM and datapath state
   state_t        state_reg, state_next;
   logic [AW-1:0] addr_reg,  addr_next;    // word index; wraps naturally
   logic [1:0]    len_reg,   len_next;
   logic [3:0]    count_reg, count_next;   // index of current beat

   // Registered outputs
   logic [1:0]    reqout_reg,      reqout_next;
   logic [2:0]    cmdout_reg,      cmdout_next;
   logic [1:0]    lenout_reg,      lenout_next;
   logic [31:0]   addrdataout_reg, addrdataout_next;
   logic [3:0]    reqtar_reg,      reqtar_next;

   // Decoded inputs and helpers
   logic          wr_req;
   logic          rd_req;
   logic          wr_beat;
   logic [AW-1:0] req_addr;
   logic [3:0]    last_beat;

   // Memory port
   logic          ram_wr_en;
   logic [AW-1:0] ram_rd_addr;
   logic [31:0]   ram_rd_data;

   assign wr_req    = selin && (cmdin == CMD_WRREQ);
   assign rd_req    = selin && (cmdin == CMD_RDREQ);
   assign wr_beat   = selin && (cmdin == CMD_WDATA);
   assign req_addr  = addrdatain[AW+1:2];
   assign last_beat = len_to_beats(len_reg) - 4'd1;

   vid_mem_ram #(
      .WORDS (MEM_WORDS)
   ) u_ram (
      .clk     (clk),
      .wr_en   (ram_wr_en),
      .wr_addr (addr_reg),
      .wr_data (addrdatain),
      .rd_addr (ram_rd_addr),
      .rd_data (ram_rd_data)
   );

   // ------------------------------------------------------------------
   // State register (also holds datapath and output registers)
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg       <= IDLE;
         addr_reg        <= '0;
         len_reg         <= '0;
         count_reg       <= '0;
         reqout_reg      <= REQ_NONE;
         cmdout_reg      <= CMD_IDLE;
         lenout_reg      <= '0;
         addrdataout_reg <= '0;
         reqtar_reg      <= '0;
      end else begin
         state_reg       <= state_next;
         addr_reg        <= addr_next;
         len_reg         <= len_next;
         count_reg       <= count_next;
         reqout_reg      <= reqout_next;
         cmdout_reg      <= cmdout_next;
         lenout_reg      <= lenout_next;
         addrdataout_reg <= addrdataout_next;
         reqtar_reg      <= reqtar_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and datapath logic
   //
   // The RAM read is registered and the output beat is registered again,
   // so the read address runs one word ahead of the beat being presented:
   // whatever sits in ram_rd_data at an edge is the beat that edge loads.
   // In IDLE the read is aimed at the incoming request address so that a
   // grant on the very first RD_BID cycle already has data waiting.
   // ------------------------------------------------------------------
   always_comb begin
      state_next  = state_reg;
      addr_next   = addr_reg;
      len_next    = len_reg;
      count_next  = count_reg;
      ram_wr_en   = 1'b0;
      ram_rd_addr = addr_reg;

      case (state_reg)
         IDLE: begin
            ram_rd_addr = req_addr;
            if (wr_req) begin
               state_next = WR_DATA;
               addr_next  = req_addr;
               len_next   = lenin;
               count_next = '0;
            end else if (rd_req) begin
               state_next = RD_BID;
               addr_next  = req_addr;
               len_next   = lenin;
               count_next = '0;
            end
         end

         WR_DATA: begin
            // Non-data cycles simply hold here without touching memory
            if (wr_beat) begin
               ram_wr_en = 1'b1;
               addr_next = addr_reg + 1'b1;
               if (count_reg == last_beat) begin
                  state_next = WR_BID;
               end else begin
                  count_next = count_reg + 4'd1;
               end
            end
         end

         WR_BID: begin
            if (ackin) begin
               state_next = IDLE;
            end
         end

         RD_BID: begin
            // Keep re-reading the start word until granted, then prefetch
            // the second beat on the grant edge.
            if (ackin) begin
               ram_rd_addr = addr_reg + 1'b1;
               addr_next   = addr_reg + 1'b1;
               state_next  = RD_DATA;
            end
         end

         RD_DATA: begin
            // addr_reg already points at the beat after the one on the bus
            ram_rd_addr = addr_reg + 1'b1;
            if (count_reg == last_beat) begin
               state_next = IDLE;
            end else begin
               count_next = count_reg + 4'd1;
               addr_next  = addr_reg + 1'b1;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output logic: values the output registers take at the next edge
   // ------------------------------------------------------------------
   always_comb begin
      reqout_next      = REQ_NONE;
      cmdout_next      = CMD_IDLE;
      lenout_next      = '0;
      addrdataout_next = '0;
      reqtar_next      = '0;

      case (state_reg)
         IDLE: begin
            if (!wr_req && rd_req) begin
               reqout_next = REQ_BID;
            end
         end

         WR_DATA: begin
            if (wr_beat && (count_reg == last_beat)) begin
               reqout_next = REQ_BID;
            end
         end

         WR_BID: begin
            if (ackin) begin
               cmdout_next = CMD_WRRESP;
               lenout_next = len_reg;
               reqtar_next = VID_ID;
            end else begin
               reqout_next = REQ_BID;
            end
         end

         RD_BID: begin
            if (ackin) begin
               // First beat; the bid drops at once for a single-beat burst
               cmdout_next      = CMD_RDATA;
               lenout_next      = len_reg;
               addrdataout_next = ram_rd_data;
               reqtar_next      = VID_ID;
               reqout_next      = (last_beat == 4'd0) ? REQ_NONE : REQ_BID;
            end else begin
               reqout_next = REQ_BID;
            end
         end

         RD_DATA: begin
            if (count_reg != last_beat) begin
               cmdout_next      = CMD_RDATA;
               lenout_next      = len_reg;
               addrdataout_next = ram_rd_data;
               reqtar_next      = VID_ID;
               reqout_next      = ((count_reg + 4'd1) == last_beat) ? REQ_NONE : REQ_BID;
            end
         end

         default: begin
            reqout_next = REQ_NONE;
         end
      endcase
   end

   assign reqout      = reqout_reg;
   assign cmdout      = cmdout_reg;
   assign lenout      = lenout_reg;
   assign addrdataout = addrdataout_reg;
   assign reqtar      = reqtar_reg;

endmodule : vid_mem_resp

// File: tb/tb_vid_mem_resp.sv
// ---------------------------------------------------------------------------
// tb_vid_mem_resp
//   Directed bench for vid_mem_resp: write/read bursts, address wrap,
//   requests arriving mid-burst, write stalls and reset during a burst.
// ---------------------------------------------------------------------------
module tb_vid_mem_resp;
   import vid_bus_pkg::*;

   localparam logic [3:0] VID = 4'h1;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        selin;
   logic [2:0]  cmdin;
   logic [1:0]  lenin;
   logic [31:0] addrdatain;
   logic        ackin;
   logic [1:0]  reqout;
   logic [2:0]  cmdout;
   logic [1:0]  lenout;
   logic [31:0] addrdataout;
   logic [3:0]  reqtar;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   vid_mem_resp #(
      .MEM_WORDS (256),
      .VID_ID    (VID)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .selin       (selin),
      .cmdin       (cmdin),
      .lenin       (lenin),
      .addrdatain  (addrdatain),
      .ackin       (ackin),
      .reqout      (reqout),
      .cmdout      (cmdout),
      .lenout      (lenout),
      .addrdataout (addrdataout),
      .reqtar      (reqtar)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".reqout"},      32'(reqout),      32'd0);
      chk({tag, ".cmdout"},      32'(cmdout),      32'd0);
      chk({tag, ".lenout"},      32'(lenout),      32'd0);
      chk({tag, ".addrdataout"}, addrdataout,      32'd0);
      chk({tag, ".reqtar"},      32'(reqtar),      32'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic [2:0] c, input logic [1:0] l,
                        input logic [31:0] ad, input logic a);
      selin      = s;
      cmdin      = c;
      lenin      = l;
      addrdatain = ad;
      ackin      = a;
   endtask

   // Write burst; stall_at inserts two non-data cycles before that beat.
   // The grant arrives on the third WR_BID cycle.
   task automatic write_burst(input logic [31:0] addr, input logic [1:0] len,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3,
                              input int stall_at);
      logic [31:0] d [4];
      int nb;
      d  = '{d0, d1, d2, d3};
      nb = 1 << len;
      $display("write addr=%h len=%0d stall_at=%0d", addr, len, stall_at);
      drive(1'b1, CMD_WRREQ, len, addr, 1'b0);
      tick();
      chk("wr_req.reqout", 32'(reqout), 32'd0);
      for (int b = 0; b < nb; b++) begin
         if (b == stall_at) begin
            drive(1'b1, CMD_IDLE, 2'b00, 32'hFFFF_FFFF, 1'b0);
            tick();
            drive(1'b0, CMD_WDATA, 2'b00, 32'hEEEE_EEEE, 1'b0);
            tick();
            chk("wr_stall.reqout", 32'(reqout), 32'd0);
         end
         drive(1'b1, CMD_WDATA, 2'b00, d[b], 1'b0);
         tick();
      end
      drive(1'b0, CMD_IDLE, 2'b00, 32'd0, 1'b0);
      chk("wr_bid.reqout", 32'(reqout), 32'(REQ_BID));
      chk("wr_bid.cmdout", 32'(cmdout), 32'd0);
      tick();
      chk("wr_bid.wait1", 32'(reqout), 32'(REQ_BID));
      tick();
      chk("wr_bid.wait2", 32'(reqout), 32'(REQ_BID));
      ackin = 1'b1;
      tick();
      ackin = 1'b0;
      chk("wr_resp.cmdout",      32'(cmdout), 32'(CMD_WRRESP));
      chk("wr_resp.reqtar",      32'(reqtar), 32'(VID));
      chk("wr_resp.reqout",      32'(reqout), 32'd0);
      chk("wr_resp.lenout",      32'(lenout), 32'(len));
      chk("wr_resp.addrdataout", addrdataout, 32'd0);
      tick();
      chk_idle("wr_done");
   endtask

   // Read burst of up to 4 beats; noise keeps a read request on the bus
   // from the grant cycle until the burst has finished.
   task automatic read_burst(input logic [31:0] addr, input logic [1:0] len,
                             input logic [31:0] d0, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] d3,
                             input int ack_dly, input bit noise);
      logic [31:0] d [4];
      int nb;
      d  = '{d0, d1, d2, d3};
      nb = 1 << len;
      $display("read  addr=%h len=%0d ack_dly=%0d noise=%0d", addr, len, ack_dly, noise);
      drive(1'b1, CMD_RDREQ, len, addr, 1'b0);
      tick();
      drive(1'b0, CMD_IDLE, 2'b00, 32'd0, 1'b0);
      chk("rd_bid.reqout", 32'(reqout), 32'(REQ_BID));
      chk("rd_bid.cmdout", 32'(cmdout), 32'd0);
      repeat (ack_dly) begin
         tick();
         chk("rd_bid.wait", 32'(reqout), 32'(REQ_BID));
      end
      ackin = 1'b1;
      if (noise) begin
         selin      = 1'b1;
         cmdin      = CMD_RDREQ;
         addrdatain = 32'h0000_0040;
      end
      tick();
      ackin = 1'b0;
      for (int b = 0; b < nb; b++) begin
         chk("rd_beat.cmdout", 32'(cmdout), 32'(CMD_RDATA));
         chk("rd_beat.data",   addrdataout, d[b]);
         chk("rd_beat.lenout", 32'(lenout), 32'(len));
         chk("rd_beat.reqtar", 32'(reqtar), 32'(VID));
         chk("rd_beat.reqout", 32'(reqout), (b == nb - 1) ? 32'd0 : 32'(REQ_BID));
         tick();
      end
      chk_idle("rd_done");
      drive(1'b0, CMD_IDLE, 2'b00, 32'd0, 1'b0);
      tick();
      chk_idle("rd_after");
   endtask

   initial begin
      reset_n = 1'b0;
      drive(1'b1, CMD_RDREQ, 2'b10, 32'h10, 1'b1);
      repeat (3) tick();
      chk_idle("reset");

      reset_n = 1'b1;
      drive(1'b0, CMD_RDREQ, 2'b10, 32'h10, 1'b0);
      tick();
      chk_idle("idle_unselected");
      drive(1'b1, CMD_WDATA, 2'b00, 32'h1234_5678, 1'b0);
      tick();
      chk_idle("idle_wdata");
      drive(1'b0, CMD_IDLE, 2'b00, 32'd0, 1'b0);
      tick();

      // Basic write then read-back
      write_burst(32'h10, 2'b10, 32'hA1, 32'hA2, 32'hA3, 32'hA4, -1);
      read_burst (32'h10, 2'b10, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 0, 1'b0);

      // Address wrap at the top of memory
      write_burst(32'h3FC, 2'b01, 32'hDEAD_00FF, 32'hBEEF_0000, 32'd0, 32'd0, -1);
      read_burst (32'h3FC, 2'b01, 32'hDEAD_00FF, 32'hBEEF_0000, 32'd0, 32'd0, 0, 1'b0);

      // Read request arriving during a burst is dropped
      read_burst (32'h10, 2'b10, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 1, 1'b1);

      // Write with stall cycles between beats
      write_burst(32'h20, 2'b10, 32'hB1, 32'hB2, 32'hB3, 32'hB4, 2);
      read_burst (32'h20, 2'b10, 32'hB1, 32'hB2, 32'hB3, 32'hB4, 2, 1'b0);

      // Reset on the second beat of a read burst
      $display("read  addr=00000010 len=2 reset on beat 2");
      drive(1'b1, CMD_RDREQ, 2'b10, 32'h10, 1'b0);
      tick();
      drive(1'b0, CMD_IDLE, 2'b00, 32'd0, 1'b1);
      tick();
      ackin = 1'b0;
      chk("rst_burst.beat1", addrdataout, 32'hA1);
      tick();
      chk("rst_burst.beat2", addrdataout, 32'hA2);
      reset_n = 1'b0;
      #1;
      chk_idle("reset_mid");
      tick();
      chk_idle("reset_hold");
      #2;
      reset_n = 1'b1;
      tick();
      chk_idle("post_reset");

      // Memory survives reset; single-beat read
      read_burst (32'h10, 2'b00, 32'hA1, 32'd0, 32'd0, 32'd0, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_vid_mem_resp
